// File: rtl/regfile_clr.sv
// regfile_clr: DEPTH x DWIDTH register file, 2 comb read ports, 1 sync write port, hardware clear sequencer; r0 reads 0.
// Latency: reads 0 cycles; writes visible next cycle (same cycle with REGFILE_BYPASS_EN defined); clear takes DEPTH-1 cycles.
// Backpressure: none; writes arriving while busy are discarded and flagged by a one-cycle wr_drop pulse.
module regfile_clr #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  input  logic              RegWEn,
  input  logic [AWIDTH-1:0] AddrD,
  input  logic [DWIDTH-1:0] DataD,
  input  logic [AWIDTH-1:0] AddrA,
  input  logic [AWIDTH-1:0] AddrB,
  output logic [DWIDTH-1:0] Data_A,
  output logic [DWIDTH-1:0] Data_B,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH-1:0] PTR_FIRST = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] PTR_LAST  = AWIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] ptr, ptr_nxt;
  logic              clr_we;
  logic              wr_ok;
  logic [DWIDTH-1:0] mem [DEPTH];

  assign busy  = (state == CLEAR);
  assign wr_ok = RegWEn && !busy && (AddrD != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      ptr     <= PTR_FIRST;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      wr_drop <= RegWEn && busy && (AddrD != '0);
    end
  end

  // clr_req is only honoured from IDLE, so a running clear is never restarted
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    clr_we    = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = PTR_FIRST;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (ptr == PTR_LAST) state_nxt = IDLE;
        else                 ptr_nxt   = ptr + AWIDTH'(1);
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = PTR_FIRST;
      end
    endcase
  end

  // Entry 0 is never written; reads of address 0 are forced to zero below
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we)     mem[ptr]   <= '0;
      else if (wr_ok) mem[AddrD] <= DataD;
    end
  end

  always_comb begin
    Data_A = '0;
    Data_B = '0;
    if (!busy) begin
      if (AddrA != '0) Data_A = mem[AddrA];
      if (AddrB != '0) Data_B = mem[AddrB];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (AddrA == AddrD)) Data_A = DataD;
      if (wr_ok && (AddrB == AddrD)) Data_B = DataD;
`endif
    end
  end

endmodule
